fir_ntap_avg_pipe: RTL and testbench
====================================

// Module: fir_ntap_avg_pipe
// PURPOSE
//  Parametrised N-tap signed moving-sum / moving-average FIR with valid-qualified
//  input, pipelined registered adder tree and selectable full-sum or rounded-average
//  output. Next generation of the 4-tap averaging filter: any power-of-2 tap count,
//  stall-tolerant input, window-fill tracking and synchronous clear. Sits between
//  the sample source and the downstream accumulator/compare logic.
// PARAMETERS
//  W     16  operand width, two's complement
//  TAPS  8   tap count; power of 2, 2..64 (elaboration error otherwise)
//  L     $clog2(TAPS), localparam: adder-tree depth; output growth bits
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      in_data is a new sample this cycle
//  in_data    in   W      signed input sample
//  avg_mode   in   1      1: rounded average; 0: full sum; sampled with in_data
//  clear      in   1      synchronous flush of delay line and fill count
//  out_valid  out  1      out_data holds a new result (one pulse per accepted sample)
//  out_data   out  W+L    signed sum, or sign-extended average
//  out_full   out  1      result window held TAPS real samples (no clear/reset zeros)
// BEHAVIOUR
//  - Reset: taps, tree registers, fill count, out_valid, out_data, out_full all 0.
//    Applies mid-operation; in-flight results discarded; out_valid low after the edge.
//  - Delay line tap[0..TAPS-1] shifts only on in_valid: tap[0]<=in_data,
//    tap[i]<=tap[i-1]. No in_valid: taps hold (stall), no result issued.
//  - Sum = sum of all TAPS taps, each sign-extended to W+L bits; overflow impossible.
//  - Pipeline: capture edge k; tree level j registered at edge k+j (j=1..L);
//    output register at edge k+L+1. Latency LAT=L+1 edges (TAPS=4 -> 3).
//    Fully pipelined: one result per cycle at back-to-back in_valid.
//  - valid, avg_mode and full flag travel with the sample through the pipeline;
//    changing avg_mode affects only samples accepted after the change.
//  - Average: out_data = (sum + 2^(L-1)) >>> L, round-half-up (toward +inf on ties),
//    sign-extended to W+L bits; result always fits in W bits.
//  - Fill count: increments per accepted sample, saturates at TAPS; full flag for
//    a sample = (count after accepting it == TAPS).
//  - clear: taps and fill count to 0 at the edge; samples already in the tree
//    drain and are issued normally. clear with in_valid same cycle: clear wins for
//    older taps, new sample loads tap[0] (others 0), count=1.
//  - out_valid high exactly one cycle per result; out_data/out_full hold between.
// TESTING  (W=16, TAPS=4, LAT=3)
//  1 reset, sum mode, samples 1,2,3,4 back-to-back -> out_data 1,3,6,10, each 3
//    edges after capture; out_full only with 10.
//  2 avg mode, 4x 0x7FFF -> sum 0x1FFFC, out_data 0x7FFF; 4x 0x8000 -> out_data
//    -32768 (sum mode: -0x20000).
//  3 avg rounding from empty window: single 1 -> 0; 2 -> 1; -2 -> 0; -3 -> -1.
//  4 samples 1,2,3,4 with 0-3 idle cycles between -> same results as test 1,
//    out_valid pulses count 4, no result during gaps.
//  5 fill 1,2,3,4 then clear+in_valid(5) -> out 5 with out_full=0; then 6,7,8 ->
//    11,18,26, out_full on 26.
//  6 reset asserted while 3 samples in flight -> no out_valid afterwards; next
//    sample 9 -> out 9, out_full=0.

Source files
------------

// File: rtl/fir_ntap_avg_pipe.sv
// -----------------------------------------------------------------------------
// fir_ntap_avg_pipe
//
// Parametrised N-tap signed moving-sum / moving-average FIR. A delay line of
// TAPS samples shifts on each accepted input, a fully registered binary adder
// tree reduces it, and a final output register selects either the full sum or
// the round-half-up average (sum >>> L). Window-fill tracking flags results
// whose window held TAPS real samples; clear flushes the delay line and fill
// count without disturbing results already inside the tree.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high; clears all state
//   in_valid   in   1       in_data carries a new sample this cycle
//   in_data    in   W       signed sample
//   avg_mode   in   1       1: rounded average, 0: full sum (sampled with in_data)
//   clear      in   1       synchronous flush of delay line and fill count
//   out_valid  out  1       one-cycle pulse per result
//   out_data   out  W+L     signed sum, or sign-extended average
//   out_full   out  1       result window held TAPS real samples
//
// Handshake: in_valid is a one-sided qualifier (no ready; every valid sample
// is accepted). out_valid pulses exactly LAT = L+1 edges after the capture
// edge; out_data/out_full hold their last values while out_valid is low.
// -----------------------------------------------------------------------------
module fir_ntap_avg_pipe #(
  parameter int W    = 16,
  parameter int TAPS = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [W-1:0]                      in_data,
  input  logic                              avg_mode,
  input  logic                              clear,
  output logic                              out_valid,
  output logic signed [W+$clog2(TAPS)-1:0]  out_data,
  output logic                              out_full
);

  localparam int L  = $clog2(TAPS);
  localparam int OW = W + L;
  localparam int CW = $clog2(TAPS + 1);

  if (TAPS < 2 || TAPS > 64 || (TAPS & (TAPS - 1)) != 0) begin : g_taps_check
    $error("fir_ntap_avg_pipe: TAPS must be a power of 2 in 2..64");
  end

  // Delay line and fill count
  logic [W-1:0]         tap_q [TAPS];
  logic [W-1:0]         tap_d [TAPS];
  logic [CW-1:0]        cnt_q, cnt_d;

  // Adder tree in heap order: node 1 is the root, node i has children 2i and
  // 2i+1. Indices TAPS..2*TAPS-1 are the (sign-extended) taps themselves, so
  // each internal node is one register stage above its children.
  logic signed [OW-1:0] node_q [1:TAPS-1];
  logic signed [OW-1:0] node_d [1:TAPS-1];
  logic signed [OW-1:0] tree_w [1:2*TAPS-1];

  // Sideband that travels with each sample: stage 0 is aligned with the taps,
  // stage j with tree depth level j, stage L with the root.
  logic [L:0]           vld_q, vld_d;
  logic [L:0]           avg_q, avg_d;
  logic [L:0]           full_q, full_d;

  // Output register
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_data_q, out_data_d;
  logic                 out_full_q, out_full_d;
  logic signed [OW-1:0] rnd_w;

  // Delay line, fill count, sideband entry
  always_comb begin
    tap_d = tap_q;
    cnt_d = cnt_q;
    if (clear) begin
      // Clear wins over older taps; a simultaneous sample still lands in tap 0.
      for (int i = 0; i < TAPS; i++) tap_d[i] = '0;
      cnt_d = '0;
      if (in_valid) begin
        tap_d[0] = in_data;
        cnt_d    = CW'(1);
      end
    end else if (in_valid) begin
      tap_d[0] = in_data;
      for (int i = 1; i < TAPS; i++) tap_d[i] = tap_q[i-1];
      if (cnt_q != CW'(TAPS)) cnt_d = cnt_q + 1'b1;
    end

    vld_d  = {vld_q[L-1:0],  in_valid};
    avg_d  = {avg_q[L-1:0],  avg_mode};
    full_d = {full_q[L-1:0], in_valid && (cnt_d == CW'(TAPS))};
  end

  // Adder tree
  always_comb begin
    for (int i = 1; i < TAPS; i++) tree_w[i] = node_q[i];
    for (int i = 0; i < TAPS; i++) tree_w[TAPS+i] = {{L{tap_q[i][W-1]}}, tap_q[i]};
    for (int i = 1; i < TAPS; i++) node_d[i] = tree_w[2*i] + tree_w[2*i+1];
  end

  // Output select: average rounds half up by adding 2^(L-1) before the
  // arithmetic shift; the sum cannot overflow OW bits even with the bias.
  always_comb begin
    rnd_w       = tree_w[1] + (OW'(1) << (L - 1));
    out_valid_d = vld_q[L];
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    if (vld_q[L]) begin
      out_data_d = avg_q[L] ? (rnd_w >>> L) : tree_w[1];
      out_full_d = full_q[L];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) tap_q[i]  <= '0;
      for (int i = 1; i < TAPS; i++) node_q[i] <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      avg_q       <= '0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      node_q      <= node_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      avg_q       <= avg_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_fir_ntap_avg_pipe.sv
// -----------------------------------------------------------------------------
// tb_fir_ntap_avg_pipe
//
// Bench for fir_ntap_avg_pipe at W=16, TAPS=4. The reference model keeps the
// sample window as a queue of integers (newest first), sums it with plain
// arithmetic and applies floor((sum + 2) / 4) for the average. Each accepted
// sample pushes {full, data} plus the cycle its result is due; a monitor pops
// and compares whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_fir_ntap_avg_pipe;

  localparam int W    = 16;
  localparam int TAPS = 4;
  localparam int L    = 2;
  localparam int OW   = W + L;
  localparam int LAT  = L + 1;

  // Clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          avg_mode;
  logic          clear;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_full;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fir_ntap_avg_pipe #(.W(W), .TAPS(TAPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .avg_mode  (avg_mode),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_full  (out_full)
  );

  // Scoreboard state
  logic [OW:0]   exp_q[$];      // {full, data}
  int            exp_cyc_q[$];  // cycle the result is due
  int            hist[$];       // model window, newest first
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out   = 0;
  logic [OW-1:0] last_data = '0;
  logic          last_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  // Driver tasks
  task automatic drive(input bit v, input int d, input bit m, input bit clr);
    longint s;
    longint r;
    bit     full;
    @(negedge clk);
    in_valid = v;
    in_data  = d[W-1:0];
    avg_mode = m;
    clear    = clr;
    if (clr) hist.delete();
    if (v) begin
      hist.push_front(d);
      if (hist.size() > TAPS) void'(hist.pop_back());
      s = 0;
      foreach (hist[i]) s += hist[i];
      full = (hist.size() == TAPS);
      r    = m ? floor_div(s + 2, 4) : s;
      exp_q.push_back({full, OW'(r)});
      exp_cyc_q.push_back(cyc + 1 + LAT);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    hist.delete();
    last_data = '0;
    last_full = 1'b0;
    @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data",  out_data,  0);
    check("reset_out_full",  out_full,  0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) drive(0, 0, 0, 0);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor
  initial begin
    logic [OW:0] e;
    int          c;
    forever begin
      @(posedge clk);
      #1;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_out: got no result, expected %0h due cycle %0d", exp_q[0], exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (out_valid === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got out_data %0h at cycle %0d, expected no result", out_data, cyc);
          last_data = out_data;
          last_full = out_full;
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("out_data", out_data, e[OW-1:0]);
          check("out_full", out_full, e[OW]);
          check("latency",  cyc,      c);
          last_data = e[OW-1:0];
          last_full = e[OW];
        end
      end else if (reset !== 1'b1) begin
        check("hold_data", out_data, last_data);
        check("hold_full", out_full, last_full);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

  // Stimulus
  int start;
  int gaps[4] = '{0, 1, 2, 3};
  int rvals[4] = '{1, 2, -2, -3};

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    avg_mode = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);

    // 1: sum mode, back-to-back 1..4
    do_reset();
    start = n_out;
    for (int i = 1; i <= 4; i++) drive(1, i, 0, 0);
    drain();
    check("t1_pulses", n_out - start, 4);

    // 2: extremes in average and sum mode
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 32767, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, -32768, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, -32768, 0, 0);
    drain();

    // 3: average rounding from an empty window
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      drive(1, rvals[i], 1, 0);
      drain();
    end

    // 4: stalls between samples
    do_reset();
    start = n_out;
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 0, 0);
      idle(gaps[i-1]);
    end
    drain();
    check("t4_pulses", n_out - start, 4);

    // 5: clear together with a new sample
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1, i, 0, 0);
    drive(1, 5, 0, 1);
    for (int i = 6; i <= 8; i++) drive(1, i, 0, 0);
    drain();

    // 6: reset with samples in flight
    do_reset();
    for (int i = 1; i <= 3; i++) drive(1, i * 100, 0, 0);
    do_reset();
    start = n_out;
    drive(1, 9, 0, 0);
    drain();
    check("t6_pulses", n_out - start, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      int d;
      r = $urandom_range(0, 199);
      case ($urandom_range(0, 7))
        0:       d = 32767;
        1:       d = -32768;
        default: d = int'($urandom_range(0, 65535)) - 32768;
      endcase
      if (r == 0) do_reset();
      else drive(r < 140, d, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
